input_conditioner: RTL and testbench
====================================

// Module: input_conditioner
// PURPOSE
//  Board-input front end for the mode/operand FSM and datapath.
//  Synchronises the raw active-low NEXT push-button, then debounces it and emits one clean pulse per press.
//  Synchronises and stability-filters the Din/MS/level slide switches.
//  The FSM consumes next_pulse; the datapath and FSM consume the stable switch values.
// PARAMETERS
//  SYNC_STAGES     2      flip-flop synchroniser depth, all raw inputs (>=2)
//  DEBOUNCE_CYCLES 250000 consecutive stable cycles required to accept a level change (>=2)
//  REPEAT_DELAY    25000000 cycles held before first auto-repeat pulse (AUTO_REPEAT_EN only)
//  REPEAT_PERIOD   5000000 cycles between later auto-repeat pulses (AUTO_REPEAT_EN only)
// PORTS
//  clk         in   1  system clock
//  clear       in   1  reset, synchronous, active-high
//  next_n_raw  in   1  raw NEXT button, 0 = pressed, asynchronous
//  din_raw     in   4  raw operand switches, asynchronous
//  ms_raw      in   3  raw mode-select switches, asynchronous
//  level_raw   in   1  raw level switch, asynchronous
//  next_pulse  out  1  one-cycle pulse per accepted press (and per repeat)
//  next_held   out  1  debounced button state, 1 = pressed
//  din_stable  out  4  filtered Din
//  ms_stable   out  3  filtered MS
//  level_stable out 1  filtered level
// BEHAVIOUR
//  Reset (clear=1 at a clk edge):
//   - all outputs are 0; FSM goes to IDLE; all counters are 0.
//   - button sync flops are 1 (released); switch sync, candidate and stable registers are 0.
//  Sync: each raw bit passes through SYNC_STAGES flops; only synchronised values are used downstream.
//  Button FSM (b = synchronised button, active-low), counter bcnt:
//   - IDLE: b==0 -> PRESS_WAIT, bcnt=0.
//   - PRESS_WAIT: b==1 -> IDLE, no pulse. Otherwise bcnt++.
//     When bcnt==DEBOUNCE_CYCLES-1 -> HELD, next_pulse=1 and next_held=1, both registered.
//   - HELD: b==1 -> RELEASE_WAIT, bcnt=0.
//   - RELEASE_WAIT: b==0 -> HELD, no new pulse. Otherwise bcnt++.
//     When bcnt==DEBOUNCE_CYCLES-1 -> IDLE, next_held=0.
//  Button latency: let E0 be the first edge that samples raw=0, with the input held low afterwards.
//   - next_pulse is high for exactly the one cycle following edge E(SYNC_STAGES+DEBOUNCE_CYCLES).
//   - Any glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no pulse, in either direction.
//  next_pulse is never high on two consecutive cycles.
//  Switch filter (8-bit vector s = {din,ms,level} after sync):
//   - s!=cand: cand=s, scnt=0.
//   - else: scnt saturates at DEBOUNCE_CYCLES-1; when saturated, stable=cand.
//   - All eight bits update together. Partial bounce restarts the count for the whole vector.
//   - Stable outputs change at most once per DEBOUNCE_CYCLES cycles.
//  Simultaneous button and switch activity: the two paths are independent.
//   - A pulse may coincide with a switch update. Consumers sample the switches on next_pulse.
//  Reset mid-operation: clear overrides everything on that edge.
//   - An in-flight PRESS_WAIT is discarded (no pulse).
//   - If the button is still held when clear drops, it is re-detected as a fresh press and
//     produces one pulse after the full latency.
//  Counter widths are $clog2(max count)+1; no counter wraps (all compare-and-reset or saturate).
// CONFIGURATION
//  AUTO_REPEAT_EN defined:
//   - In HELD, rcnt counts from 0. At rcnt==REPEAT_DELAY-1 one pulse fires and rcnt reloads.
//   - After that, one pulse fires every REPEAT_PERIOD cycles while in HELD.
//   - Leaving HELD (RELEASE_WAIT) clears rcnt.
//  AUTO_REPEAT_EN undefined:
//   - Exactly one pulse per press; rcnt logic and the REPEAT_* parameters are absent/unused.
// TESTING (bench params: SYNC_STAGES=2 DEBOUNCE_CYCLES=4 REPEAT_DELAY=8 REPEAT_PERIOD=3)
//  1 clear 3 cycles, then idle -> all outputs 0 and next_held=0, for 20 cycles.
//  2 next_n_raw 1->0 at E0, held 20 cycles -> next_pulse=1 only in the cycle after E6.
//    next_held=1 from that cycle on.
//  3 Bounce 0,1,0,0,1 (one cycle each), then 1 -> no next_pulse and next_held stays 0.
//    Repeat on release while held: next_held stays 1 and no extra pulse.
//  4 din_raw=4'hA, ms_raw=3'b101 applied together and held -> stable outputs update 2+4+1 cycles later.
//    Flipping one bit back after 2 cycles -> outputs unchanged.
//  5 clear asserted during PRESS_WAIT, then released with button still low -> no pulse during clear.
//    One pulse 6 cycles after clear drops.
//  6 AUTO_REPEAT_EN, hold 30 cycles -> pulses at entry into HELD, +8, then every +3 until release.
//    Undefined -> single pulse.

Source files
------------

// File: rtl/input_conditioner.sv
// Board-input front end: synchronises and debounces the active-low NEXT button into one pulse per press,
// and synchronises and stability-filters the Din/MS/level switches. Optional auto-repeat: AUTO_REPEAT_EN.
module input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000
`ifdef AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
`endif
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       next_n_raw,
    input  logic [3:0] din_raw,
    input  logic [2:0] ms_raw,
    input  logic       level_raw,
    output logic       next_pulse,
    output logic       next_held,
    output logic [3:0] din_stable,
    output logic [2:0] ms_stable,
    output logic       level_stable
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

`ifdef AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = $clog2(RMAX) + 1;
    localparam logic [RW-1:0] RCNT_DELAY  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RCNT_PERIOD = RW'(REPEAT_PERIOD - 1);
    localparam logic [RW-1:0] RCNT_ONE    = {{(RW-1){1'b0}}, 1'b1};
`endif

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_e;

    state_e                        state_q;
    logic [CW-1:0]                 bcnt_q;
    logic                          next_pulse_q;
    logic                          next_held_q;
    logic [SYNC_STAGES-1:0]        bsync_q;
    logic [SYNC_STAGES-1:0][7:0]   ssync_q;
    logic [7:0]                    cand_q;
    logic [7:0]                    stable_q;
    logic [CW-1:0]                 scnt_q;
    logic                          btn_sync;
    logic [7:0]                    sw_sync;

`ifdef AUTO_REPEAT_EN
    logic [RW-1:0]                 rcnt_q;
    logic                          rep_armed_q;
    logic [RW-1:0]                 rcnt_lim_d;
    assign rcnt_lim_d = rep_armed_q ? RCNT_PERIOD : RCNT_DELAY;
`endif

    assign btn_sync = bsync_q[SYNC_STAGES-1];
    assign sw_sync  = ssync_q[SYNC_STAGES-1];

    // Synchroniser chains; the button idles released (1) out of reset.
    always_ff @(posedge clk) begin
        if (clear) begin
            bsync_q <= '1;
            ssync_q <= '0;
        end else begin
            bsync_q <= {bsync_q[SYNC_STAGES-2:0], next_n_raw};
            ssync_q <= {ssync_q[SYNC_STAGES-2:0], {din_raw, ms_raw, level_raw}};
        end
    end

    // Whole-vector switch filter: any bit change restarts the stability count.
    always_ff @(posedge clk) begin
        if (clear) begin
            cand_q   <= 8'h00;
            scnt_q   <= '0;
            stable_q <= 8'h00;
        end else if (sw_sync != cand_q) begin
            cand_q <= sw_sync;
            scnt_q <= '0;
        end else if (scnt_q == CNT_MAX) begin
            stable_q <= cand_q;
        end else begin
            scnt_q <= scnt_q + CNT_ONE;
        end
    end

    // Button debounce FSM with registered pulse and held outputs.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q      <= IDLE;
            bcnt_q       <= '0;
            next_pulse_q <= 1'b0;
            next_held_q  <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rcnt_q       <= '0;
            rep_armed_q  <= 1'b0;
`endif
        end else begin
            next_pulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!btn_sync) begin
                        state_q <= PRESS_WAIT;
                        bcnt_q  <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (btn_sync) begin
                        state_q <= IDLE;
                    end else if (bcnt_q == CNT_MAX) begin
                        state_q      <= HELD;
                        next_pulse_q <= 1'b1;
                        next_held_q  <= 1'b1;
                    end else begin
                        bcnt_q <= bcnt_q + CNT_ONE;
                    end
                end
                HELD: begin
                    if (btn_sync) begin
                        state_q <= RELEASE_WAIT;
                        bcnt_q  <= '0;
`ifdef AUTO_REPEAT_EN
                        rcnt_q      <= '0;
                        rep_armed_q <= 1'b0;
                    end else if (rcnt_q == rcnt_lim_d) begin
                        next_pulse_q <= 1'b1;
                        rcnt_q       <= '0;
                        rep_armed_q  <= 1'b1;
                    end else begin
                        rcnt_q <= rcnt_q + RCNT_ONE;
                    end
`else
                    end
`endif
                end
                RELEASE_WAIT: begin
                    if (!btn_sync) begin
                        state_q <= HELD;
                    end else if (bcnt_q == CNT_MAX) begin
                        state_q     <= IDLE;
                        next_held_q <= 1'b0;
                    end else begin
                        bcnt_q <= bcnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    next_held_q <= 1'b0;
                end
            endcase
        end
    end

    assign next_pulse   = next_pulse_q;
    assign next_held    = next_held_q;
    assign din_stable   = stable_q[7:4];
    assign ms_stable    = stable_q[3:1];
    assign level_stable = stable_q[0];

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: expected pulse cycles are queued when the button is driven
// and matched against next_pulse each cycle; held/switch outputs are checked per cycle.
module tb_input_conditioner;

    localparam int RD = 8;
    localparam int RP = 3;

    logic       clk = 1'b0;
    logic       clear;
    logic       next_n_raw;
    logic [3:0] din_raw;
    logic [2:0] ms_raw;
    logic       level_raw;
    logic       next_pulse;
    logic       next_held;
    logic [3:0] din_stable;
    logic [2:0] ms_stable;
    logic       level_stable;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    int exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    input_conditioner #(
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4)
`ifdef AUTO_REPEAT_EN
        ,
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
`endif
    ) dut (
        .clk(clk),
        .clear(clear),
        .next_n_raw(next_n_raw),
        .din_raw(din_raw),
        .ms_raw(ms_raw),
        .level_raw(level_raw),
        .next_pulse(next_pulse),
        .next_held(next_held),
        .din_stable(din_stable),
        .ms_stable(ms_stable),
        .level_stable(level_stable)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
        end
    endtask

    // One clock, then match next_pulse against the queued pulse cycles.
    task automatic tick();
        int exp_c;
        @(posedge clk);
        #1;
        if (next_pulse === 1'b1) begin
            exp_c = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            vectors++;
            assert (cyc === exp_c) else begin
                miscompares++;
                $error("FAIL pulse_cycle observed=%0d expected=%0d", cyc, exp_c);
            end
        end else if (exp_q.size() > 0 && cyc >= exp_q[0]) begin
            exp_c = exp_q.pop_front();
            vectors++;
            assert (next_pulse === 1'b1) else begin
                miscompares++;
                $error("FAIL missed_pulse cycle=%0d observed=%b expected=1", exp_c, next_pulse);
            end
        end
    endtask

    // Entry pulse plus any auto-repeats while HELD; the FSM still sees the button low up to rel+2.
    function automatic void push_press(int entry, int rel);
        int t;
        exp_q.push_back(entry);
`ifdef AUTO_REPEAT_EN
        t = entry + RD;
        while (t <= rel + 2) begin
            exp_q.push_back(t);
            t += RP;
        end
`else
        t = rel;
`endif
    endfunction

    task automatic release_check(input string tag);
        int r;
        next_n_raw = 1'b1;
        r = cyc;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk(tag, next_held, (cyc < r + 7));
        end
    endtask

    task automatic press_hold(input int n, input string tag);
        int c;
        c = cyc;
        next_n_raw = 1'b0;
        push_press(c + 7, c + n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk(tag, next_held, (cyc >= c + 7));
        end
        release_check({tag, "_rel"});
    endtask

    initial begin
        int c;
        logic bounce_a[6];
        logic bounce_b[5];
        logic [7:0] sw_obs;
        bounce_a = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        bounce_b = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        clear = 1'b1;
        next_n_raw = 1'b1;
        din_raw = 4'h0;
        ms_raw = 3'b000;
        level_raw = 1'b0;
        repeat (3) begin
            tick();
            chk("reset", {next_pulse, next_held, din_stable, ms_stable, level_stable}, 10'h000);
        end
        clear = 1'b0;

        // idle after reset
        repeat (20) begin
            tick();
            chk("idle", {next_pulse, next_held, din_stable, ms_stable, level_stable}, 10'h000);
        end

        // clean press held for 20 cycles
        press_hold(20, "press20");

        // press-side bounce: no pulse, never held
        for (int i = 0; i < 6; i++) begin
            next_n_raw = bounce_a[i];
            tick();
            chk("bounce_press", next_held, 1'b0);
        end
        repeat (10) begin
            tick();
            chk("bounce_press_tail", next_held, 1'b0);
        end

        // release-side bounce while held: stays held, no extra pulse
        c = cyc;
        next_n_raw = 1'b0;
        exp_q.push_back(c + 7);
        repeat (7) begin
            tick();
            chk("bounce_rel_press", next_held, (cyc >= c + 7));
        end
        for (int i = 0; i < 5; i++) begin
            next_n_raw = bounce_b[i];
            tick();
            chk("bounce_rel", next_held, 1'b1);
        end
        repeat (4) begin
            tick();
            chk("bounce_rel_hold", next_held, 1'b1);
        end
        release_check("bounce_rel_final");

        // switches: clean change lands 7 edges after driving
        c = cyc;
        din_raw = 4'hA;
        ms_raw = 3'b101;
        repeat (10) begin
            tick();
            sw_obs = {din_stable, ms_stable, level_stable};
            chk("sw_update", sw_obs, (cyc >= c + 7) ? 8'b1010_101_0 : 8'h00);
        end

        // partial bounce: one bit flips back after 2 cycles, count restarts for the vector
        c = cyc;
        din_raw = 4'h5;
        ms_raw = 3'b010;
        level_raw = 1'b1;
        repeat (2) begin
            tick();
            sw_obs = {din_stable, ms_stable, level_stable};
            chk("sw_bounce", sw_obs, 8'b1010_101_0);
        end
        din_raw = 4'h4;
        repeat (10) begin
            tick();
            sw_obs = {din_stable, ms_stable, level_stable};
            chk("sw_bounce", sw_obs, (cyc >= c + 9) ? 8'b0100_010_1 : 8'b1010_101_0);
        end

        // clear during PRESS_WAIT, button still low when clear drops
        c = cyc;
        next_n_raw = 1'b0;
        repeat (4) begin
            tick();
            chk("clr_prewait", next_held, 1'b0);
        end
        clear = 1'b1;
        repeat (3) begin
            tick();
            chk("clr_active", {next_pulse, next_held, din_stable, ms_stable, level_stable}, 10'h000);
        end
        clear = 1'b0;
        c = cyc;
        push_press(c + 7, c + 7);
        repeat (7) begin
            tick();
            chk("clr_repress", next_held, (cyc >= c + 7));
            sw_obs = {din_stable, ms_stable, level_stable};
            chk("clr_sw", sw_obs, (cyc >= c + 7) ? 8'b0100_010_1 : 8'h00);
        end
        release_check("clr_rel");

        // long hold: single pulse, or entry/+8/every +3 with auto-repeat
        press_hold(30, "hold30");

        vectors++;
        assert (exp_q.size() === 0) else begin
            miscompares++;
            $error("FAIL leftover_pulses observed=%0d expected=0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
